// File: rtl/pll_reset_ctrl_pkg.sv
// ============================================================================
//  pll_reset_ctrl_pkg : shared FSM encoding, default timing and helpers
//  Rev 1.0
// ============================================================================
`default_nettype none

package pll_reset_ctrl_pkg;

   typedef enum logic [1:0] {
      RST_PLL   = 2'd0,
      WAIT_LOCK = 2'd1,
      SETTLE    = 2'd2,
      RUN       = 2'd3
   } state_e;

   localparam int DEF_PLL_RST_CYCLES = 16;
   localparam int DEF_LOCK_TIMEOUT   = 100000;
   localparam int DEF_SETTLE_CYCLES  = 1024;
   localparam int DEF_CNT_W          = 17;

   // Event counters stick at all-ones instead of wrapping.
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pll_reset_ctrl_sync_2ff.sv
// ============================================================================
//  sync_2ff : generic two-flop synchroniser with synchronous clear
//  Rev 1.0
// ============================================================================
`default_nettype none

module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/pll_reset_ctrl.sv
// ============================================================================
//  pll_reset_ctrl : PLL reset / lock sequencer gating the PMA/PCS reset
//  Rev 1.0
// ============================================================================
`default_nettype none

module pll_reset_ctrl
   import pll_reset_ctrl_pkg::*;
#(
   parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
   parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
   parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
   parameter int CNT_W          = DEF_CNT_W
) (
   input  logic       clk_in,
   input  logic       reset,
   input  logic       locked,
   output logic       pll_reset,
   output logic       pma_reset,
   output logic       ready,
   output logic [7:0] retry_count,
   output logic [7:0] loss_count
);

   localparam logic [CNT_W-1:0] C_RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] C_SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

   logic             locked_s;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       retry_q, retry_d;
   logic [7:0]       loss_q, loss_d;
   logic             pll_reset_q, pma_reset_q, ready_q;

   sync_2ff #(
      .WIDTH (1)
   ) u_lock_sync (
      .clk_i (clk_in),
      .rst_i (reset),
      .d_i   (locked),
      .q_o   (locked_s)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      retry_d = retry_q;
      loss_d  = loss_q;
      case (state_q)
         RST_PLL: begin
            if (cnt_q == C_RST_LAST) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end
         end
         WAIT_LOCK: begin
            // Lock arriving on the timeout cycle takes precedence over a retry.
            if (locked_s) begin
               state_d = SETTLE;
               cnt_d   = '0;
            end else if (cnt_q == C_TMO_LAST) begin
               state_d = RST_PLL;
               cnt_d   = '0;
               retry_d = sat_inc(retry_q);
            end
         end
         SETTLE: begin
            if (!locked_s) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == C_SETTLE_LAST) begin
               state_d = RUN;
               cnt_d   = '0;
            end
         end
         RUN: begin
            cnt_d = '0;
            if (!locked_s) begin
               state_d = RST_PLL;
               loss_d  = sat_inc(loss_q);
            end
         end
         default: begin
            state_d = RST_PLL;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs decode the next state so they switch on the same edge as state_q.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q     <= RST_PLL;
         cnt_q       <= '0;
         retry_q     <= 8'd0;
         loss_q      <= 8'd0;
         pll_reset_q <= 1'b1;
         pma_reset_q <= 1'b1;
         ready_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         loss_q      <= loss_d;
         pll_reset_q <= (state_d == RST_PLL);
         pma_reset_q <= (state_d != RUN);
         ready_q     <= (state_d == RUN);
      end
   end

   assign pll_reset   = pll_reset_q;
   assign pma_reset   = pma_reset_q;
   assign ready       = ready_q;
   assign retry_count = retry_q;
   assign loss_count  = loss_q;

endmodule

`default_nettype wire

// File: tb/tb_pll_reset_ctrl.sv
// ============================================================================
//  tb_pll_reset_ctrl : vector table plus retry-saturation run for pll_reset_ctrl
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_pll_reset_ctrl;

   logic       clk_in = 1'b0;
   logic       reset;
   logic       locked;
   logic       pll_reset;
   logic       pma_reset;
   logic       ready;
   logic [7:0] retry_count;
   logic [7:0] loss_count;

   typedef struct {
      string name;
      bit    rst;
      bit    lk;
      int    n;
      bit    pll;
      bit    pma;
      bit    rdy;
      int    retry;
      int    loss;
   } vec_t;

   typedef struct {
      string      name;
      bit         pll;
      bit         pma;
      bit         rdy;
      logic [7:0] retry;
      logic [7:0] loss;
   } exp_t;

   vec_t vecs[$];
   exp_t exp_q[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   pll_reset_ctrl #(
      .PLL_RST_CYCLES (4),
      .LOCK_TIMEOUT   (20),
      .SETTLE_CYCLES  (8),
      .CNT_W          (17)
   ) dut (
      .clk_in      (clk_in),
      .reset       (reset),
      .locked      (locked),
      .pll_reset   (pll_reset),
      .pma_reset   (pma_reset),
      .ready       (ready),
      .retry_count (retry_count),
      .loss_count  (loss_count)
   );

   always #5 clk_in = ~clk_in;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   task automatic add(input string nm, input bit r, input bit l, input int n,
                      input bit pll, input bit pma, input bit rdy,
                      input int rt, input int ls);
      vec_t v;
      v.name = nm; v.rst = r; v.lk = l; v.n = n;
      v.pll = pll; v.pma = pma; v.rdy = rdy; v.retry = rt; v.loss = ls;
      vecs.push_back(v);
   endtask

   task automatic push_exp(input string nm, input bit pll, input bit pma,
                           input bit rdy, input int rt, input int ls);
      exp_t e;
      e.name = nm; e.pll = pll; e.pma = pma; e.rdy = rdy;
      e.retry = 8'(rt); e.loss = 8'(ls);
      exp_q.push_back(e);
   endtask

   task automatic check_one();
      exp_t e;
      n_vec++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL scoreboard_empty: got no expected entry, want one");
      end else begin
         e = exp_q.pop_front();
         if (pll_reset !== e.pll || pma_reset !== e.pma || ready !== e.rdy ||
             retry_count !== e.retry || loss_count !== e.loss) begin
            n_fail++;
            $display("FAIL %s: got pll=%0b pma=%0b rdy=%0b retry=%0d loss=%0d, want pll=%0b pma=%0b rdy=%0b retry=%0d loss=%0d",
                     e.name, pll_reset, pma_reset, ready, retry_count, loss_count,
                     e.pll, e.pma, e.rdy, e.retry, e.loss);
         end
      end
   endtask

   initial begin
      reset  = 1'b1;
      locked = 1'b0;

      // Timeout/retry: 4 cycles in reset, 20 waiting, then retry.
      add("s1_reset",        1, 0,  2, 1, 1, 0, 0, 0);
      add("s1_prst_hold",    0, 0,  3, 1, 1, 0, 0, 0);
      add("s1_wait_enter",   0, 0,  1, 0, 1, 0, 0, 0);
      add("s1_wait_last",    0, 0, 19, 0, 1, 0, 0, 0);
      add("s1_retry",        0, 0,  1, 1, 1, 0, 1, 0);
      add("s1_prst_again",   0, 0,  3, 1, 1, 0, 1, 0);
      add("s1_wait_again",   0, 0,  1, 0, 1, 0, 1, 0);
      // Lock 5 cycles into WAIT_LOCK, full settle, then RUN.
      add("s2_reset",        1, 0,  1, 1, 1, 0, 0, 0);
      add("s2_wait",         0, 0,  9, 0, 1, 0, 0, 0);
      add("s2_settle_last",  0, 1, 10, 0, 1, 0, 0, 0);
      add("s2_run",          0, 1,  1, 0, 0, 1, 0, 0);
      // Loss of lock in RUN: reaction after exactly 3 cycles, then re-sequence.
      add("s4_sync_delay",   0, 0,  2, 0, 0, 1, 0, 0);
      add("s4_loss",         0, 0,  1, 1, 1, 0, 0, 1);
      add("s4_prst",         0, 1,  3, 1, 1, 0, 0, 1);
      add("s4_wait",         0, 1,  1, 0, 1, 0, 0, 1);
      add("s4_settle_last",  0, 1,  8, 0, 1, 0, 0, 1);
      add("s4_run",          0, 1,  1, 0, 0, 1, 0, 1);
      // One-cycle reset while running.
      add("s5_reset",        1, 1,  1, 1, 1, 0, 0, 0);
      add("s5_resettle",     0, 1, 12, 0, 1, 0, 0, 0);
      add("s5_run",          0, 1,  1, 0, 0, 1, 0, 0);
      // Lock drop inside SETTLE restarts the whole settle window.
      add("s3_reset",        1, 0,  1, 1, 1, 0, 0, 0);
      add("s3_wait",         0, 0,  4, 0, 1, 0, 0, 0);
      add("s3_settle",       0, 1,  5, 0, 1, 0, 0, 0);
      add("s3_drop",         0, 0,  3, 0, 1, 0, 0, 0);
      add("s3_resettle",     0, 1, 10, 0, 1, 0, 0, 0);
      add("s3_run",          0, 1,  1, 0, 0, 1, 0, 0);
      // Lock seen on the very timeout cycle wins over retry.
      add("s6_reset",        1, 0,  1, 1, 1, 0, 0, 0);
      add("s6_wait",         0, 0, 21, 0, 1, 0, 0, 0);
      add("s6_lock_on_tmo",  0, 1,  3, 0, 1, 0, 0, 0);
      add("s6_settle_last",  0, 1,  7, 0, 1, 0, 0, 0);
      add("s6_run",          0, 1,  1, 0, 0, 1, 0, 0);

      foreach (vecs[i]) begin
         reset  = vecs[i].rst;
         locked = vecs[i].lk;
         push_exp(vecs[i].name, vecs[i].pll, vecs[i].pma, vecs[i].rdy,
                  vecs[i].retry, vecs[i].loss);
         tick(vecs[i].n);
         check_one();
      end

      // Retry counter saturation: one retry every 24 cycles with no lock.
      reset  = 1'b1;
      locked = 1'b0;
      tick(1);
      reset = 1'b0;
      for (int k = 1; k <= 300; k++) begin
         push_exp($sformatf("sat_retry_%0d", k), 1, 1, 0, (k > 255) ? 255 : k, 0);
         tick(24);
         check_one();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
